horno_multizona: RTL and testbench



---
 rtl/horno_pkg.sv | 24 ++
 rtl/horno_tick.sv | 27 ++
 rtl/horno_multizona.sv | 143 ++++++++++++++
 tb/tb_horno_multizona.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/horno_pkg.sv
// Shared definitions for the multi-zone oven controller: state encodings,
// LED bit positions and the ADC-to-temperature scaling helper.
package horno_pkg;

  localparam int LED_IDLE    = 0;
  localparam int LED_PREHEAT = 1;
  localparam int LED_HOLD    = 2;
  localparam int LED_DONE    = 3;
  localparam int LED_FAULT   = 4;

  // One-hot states whose bit positions match the LED outputs, so led is the state register.
  typedef enum logic [4:0] {
    ST_IDLE    = 5'(1 << LED_IDLE),
    ST_PREHEAT = 5'(1 << LED_PREHEAT),
    ST_HOLD    = 5'(1 << LED_HOLD),
    ST_DONE    = 5'(1 << LED_DONE),
    ST_FAULT   = 5'(1 << LED_FAULT)
  } state_t;

  function automatic logic [31:0] adc_to_temp(input logic [31:0] sample, input int shift);
    return sample >> shift;
  endfunction

endpackage

// File: rtl/horno_tick.sv
// Seconds-tick divider: counts 0..TICK_DIV-1 while enabled and pulses tick
// for the single cycle spent at the terminal count.
module horno_tick #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
  end

  assign tick = en & (cnt == LAST);

endmodule

// File: rtl/horno_multizona.sv
// Multi-zone oven controller: per-zone hysteresis heaters against one shared
// setpoint, seconds-based hold timer, latched over-temperature fault.
module horno_multizona
  import horno_pkg::*;
#(
  parameter int N_ZONES  = 2,
  parameter int ADC_W    = 12,
  parameter int TEMP_W   = 8,
  parameter int TIMER_W  = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int HYST     = 2,
  parameter int T_MAX    = 240
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [N_ZONES*ADC_W-1:0] adc,
  input  logic [TEMP_W-1:0]        set_temp,
  input  logic [TIMER_W-1:0]       set_timer,
  output logic [N_ZONES-1:0]       heater,
  output logic [4:0]               led,
  output logic [TIMER_W-1:0]       remaining,
  output logic                     done,
  output logic                     fault
);

  localparam int SHIFT = ADC_W - TEMP_W;

  state_t               state;
  logic                 start_q;
  logic [TEMP_W-1:0]    set_temp_q;
  logic [TIMER_W-1:0]   set_timer_q;
  logic [TEMP_W:0]      lo;
  logic [N_ZONES-1:0]   over;
  logic [N_ZONES-1:0]   at_set;
  logic [N_ZONES-1:0]   heater_hyst;
  logic                 start_pulse;
  logic                 any_over;
  logic                 all_at_set;
  logic                 tick;

  assign start_pulse = start & ~start_q;
  assign any_over    = |over;
  assign all_at_set  = &at_set;

  // Lower hysteresis edge, clamped so small setpoints do not wrap.
  assign lo = ({1'b0, set_temp_q} >= (TEMP_W+1)'(HYST))
            ? {1'b0, set_temp_q} - (TEMP_W+1)'(HYST) : '0;

  for (genvar i = 0; i < N_ZONES; i++) begin : g_zone
    logic [TEMP_W-1:0] temp;
    assign temp           = TEMP_W'(adc_to_temp(32'(adc[i*ADC_W +: ADC_W]), SHIFT));
    assign over[i]        = {1'b0, temp} >= (TEMP_W+1)'(T_MAX);
    assign at_set[i]      = temp >= set_temp_q;
    assign heater_hyst[i] = ({1'b0, temp} < lo) ? 1'b1 : (at_set[i] ? 1'b0 : heater[i]);
  end

  // Counter idles at zero outside HOLD, so each hold second starts full length.
  horno_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != ST_HOLD),
    .en    (state == ST_HOLD),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      start_q     <= 1'b0;
      set_temp_q  <= '0;
      set_timer_q <= '0;
      heater      <= '0;
      remaining   <= '0;
    end else begin
      start_q <= start;
      case (state)
        ST_IDLE, ST_DONE: begin
          heater <= '0;
          if (stop) begin
            state     <= ST_IDLE;
            remaining <= '0;
          end else if (start_pulse) begin
            set_temp_q  <= set_temp;
            set_timer_q <= set_timer;
            state       <= (set_timer == '0) ? ST_DONE : ST_PREHEAT;
          end
        end
        ST_PREHEAT: begin
          if (stop) begin
            state     <= ST_IDLE;
            heater    <= '0;
            remaining <= '0;
          end else if (any_over) begin
            state  <= ST_FAULT;
            heater <= '0;
          end else begin
            heater <= heater_hyst;
            if (all_at_set) begin
              state     <= ST_HOLD;
              remaining <= set_timer_q;
            end
          end
        end
        ST_HOLD: begin
          if (stop) begin
            state     <= ST_IDLE;
            heater    <= '0;
            remaining <= '0;
          end else if (any_over) begin
            state  <= ST_FAULT;
            heater <= '0;
          end else if (tick && remaining == TIMER_W'(1)) begin
            state     <= ST_DONE;
            heater    <= '0;
            remaining <= '0;
          end else begin
            heater <= heater_hyst;
            if (tick) remaining <= remaining - TIMER_W'(1);
          end
        end
        ST_FAULT: begin
          heater <= '0;
          if (stop && !any_over) begin
            state     <= ST_IDLE;
            remaining <= '0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          heater    <= '0;
          remaining <= '0;
        end
      endcase
    end
  end

  assign led   = state;
  assign done  = state[LED_DONE];
  assign fault = state[LED_FAULT];

endmodule

// File: tb/tb_horno_multizona.sv
// Self-checking bench for horno_multizona: directed walk through the main
// scenarios, then randomized stimulus, all compared against a cycle model.
module tb_horno_multizona;

  localparam int N_ZONES  = 2;
  localparam int ADC_W    = 12;
  localparam int TEMP_W   = 8;
  localparam int TIMER_W  = 4;
  localparam int TICK_DIV = 4;
  localparam int HYST     = 2;
  localparam int T_MAX    = 240;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     start;
  logic                     stop;
  logic [N_ZONES*ADC_W-1:0] adc;
  logic [TEMP_W-1:0]        set_temp;
  logic [TIMER_W-1:0]       set_timer;
  logic [N_ZONES-1:0]       heater;
  logic [4:0]               led;
  logic [TIMER_W-1:0]       remaining;
  logic                     done;
  logic                     fault;

  int checks = 0;
  int errors = 0;

  horno_multizona #(
    .N_ZONES(N_ZONES), .ADC_W(ADC_W), .TEMP_W(TEMP_W), .TIMER_W(TIMER_W),
    .TICK_DIV(TICK_DIV), .HYST(HYST), .T_MAX(T_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .adc(adc),
    .set_temp(set_temp), .set_timer(set_timer), .heater(heater), .led(led),
    .remaining(remaining), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers, one step per rising edge.
  typedef enum int {M_IDLE, M_PRE, M_HOLD, M_DONE, M_FAULT} mstate_t;
  mstate_t          m_state;
  bit [N_ZONES-1:0] m_heater;
  int               m_rem, m_sp, m_tm, m_hold_cyc;
  bit               m_start_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] model_led(input mstate_t s);
    case (s)
      M_IDLE:  return 5'b00001;
      M_PRE:   return 5'b00010;
      M_HOLD:  return 5'b00100;
      M_DONE:  return 5'b01000;
      default: return 5'b10000;
    endcase
  endfunction

  task automatic model_step();
    int  t[N_ZONES];
    int  lo;
    bit  hot, all_set, sp;
    bit [N_ZONES-1:0] nh;
    if (!rst_n) begin
      m_state = M_IDLE; m_heater = '0; m_rem = 0; m_sp = 0; m_tm = 0;
      m_start_prev = 0; m_hold_cyc = 0;
      return;
    end
    sp = start && !m_start_prev;
    m_start_prev = start;
    hot = 0; all_set = 1;
    for (int z = 0; z < N_ZONES; z++) begin
      t[z] = int'(adc[z*ADC_W +: ADC_W]) / (1 << (ADC_W - TEMP_W));
      if (t[z] >= T_MAX) hot = 1;
      if (t[z] < m_sp) all_set = 0;
    end
    lo = (m_sp >= HYST) ? m_sp - HYST : 0;
    for (int z = 0; z < N_ZONES; z++)
      nh[z] = (t[z] < lo) ? 1'b1 : ((t[z] >= m_sp) ? 1'b0 : m_heater[z]);
    case (m_state)
      M_IDLE, M_DONE: begin
        m_heater = '0;
        if (stop) begin m_state = M_IDLE; m_rem = 0; end
        else if (sp) begin
          m_sp = int'(set_temp); m_tm = int'(set_timer);
          m_state = (m_tm == 0) ? M_DONE : M_PRE;
        end
      end
      M_PRE, M_HOLD: begin
        if (stop) begin m_state = M_IDLE; m_heater = '0; m_rem = 0; end
        else if (hot) begin m_state = M_FAULT; m_heater = '0; end
        else if (m_state == M_PRE) begin
          m_heater = nh;
          if (all_set) begin m_state = M_HOLD; m_rem = m_tm; m_hold_cyc = 0; end
        end else begin
          m_heater = nh;
          if (m_hold_cyc == TICK_DIV - 1) begin
            m_hold_cyc = 0;
            m_rem--;
            if (m_rem == 0) begin m_state = M_DONE; m_heater = '0; end
          end else m_hold_cyc++;
        end
      end
      default: begin
        m_heater = '0;
        if (stop && !hot) begin m_state = M_IDLE; m_rem = 0; end
      end
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("led", 32'(led), 32'(model_led(m_state)));
    check("heater", 32'(heater), 32'(m_heater));
    check("remaining", 32'(remaining), 32'(m_rem));
    check("done", 32'(done), 32'(m_state == M_DONE));
    check("fault", 32'(fault), 32'(m_state == M_FAULT));
  endtask

  task automatic set_adc(input int a0, input int a1);
    adc = {12'(a1), 12'(a0)};
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; stop = 1'b0; set_adc(0, 0);
    set_temp = '0; set_timer = '0;

    // Reset with start held high
    repeat (2) cycle();
    check("rst_led", 32'(led), 32'h01);
    check("rst_heater", 32'(heater), 32'h0);
    rst_n = 1'b1; stop = 1'b1;
    cycle();
    stop = 1'b0;
    repeat (3) cycle();
    check("held_start_idle", 32'(led), 32'h01);
    start = 1'b0;
    cycle();

    // Normal run
    set_temp = 8'd150; set_timer = 4'd3; set_adc(2025, 2025); start = 1'b1;
    cycle();
    check("preheat", 32'(led), 32'h02);
    start = 1'b0;
    cycle();
    check("heat_on", 32'(heater), 32'h3);
    set_adc(2400, 2400);
    cycle();
    check("hold_entry", 32'(led), 32'h04);
    check("hold_rem", 32'(remaining), 32'd3);
    repeat (12) cycle();
    check("done_led", 32'(led), 32'h08);
    check("done_flag", 32'(done), 32'd1);

    // Hysteresis on zone 0 during HOLD
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    set_adc(2384, 2400); cycle();
    check("hyst_149", 32'(heater), 32'h0);
    set_adc(2352, 2400); cycle();
    check("hyst_147", 32'(heater), 32'h1);
    set_adc(2400, 2400); cycle();
    check("hyst_150", 32'(heater), 32'h0);
    check("hyst_rem", 32'(remaining), 32'd3);

    // Over-temperature fault and its exit
    set_adc(2400, 3840); cycle();
    check("fault_flag", 32'(fault), 32'd1);
    stop = 1'b1; cycle();
    check("fault_sticky", 32'(led), 32'h10);
    set_adc(2400, 3824); cycle();
    check("fault_exit", 32'(led), 32'h01);
    stop = 1'b0;

    // Abort from HOLD, then simultaneous start/stop
    set_adc(2400, 2400); start = 1'b1; cycle();
    start = 1'b0; cycle();
    repeat (4) cycle();
    check("abort_rem2", 32'(remaining), 32'd2);
    stop = 1'b1; cycle();
    check("abort_idle", 32'(led), 32'h01);
    check("abort_rem0", 32'(remaining), 32'd0);
    stop = 1'b0; cycle();
    start = 1'b1; stop = 1'b1; cycle();
    check("stop_wins", 32'(led), 32'h01);
    start = 1'b0; stop = 1'b0; cycle();

    // Zero timer goes straight to DONE
    set_timer = 4'd0; start = 1'b1; cycle();
    check("zero_done", 32'(done), 32'd1);
    check("zero_heater", 32'(heater), 32'h0);
    start = 1'b0; cycle();
    set_timer = 4'd2; start = 1'b1; cycle();
    check("rerun_pre", 32'(led), 32'h02);
    start = 1'b0; cycle();

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      int st, a[N_ZONES];
      rst_n = ($urandom_range(0, 599) != 0);
      stop  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 5) == 0) start = ~start;
      if (!start && $urandom_range(0, 3) == 0) begin
        set_temp  = 8'($urandom_range(0, 235));
        set_timer = 4'($urandom_range(0, 3));
      end
      st = int'(set_temp);
      for (int z = 0; z < N_ZONES; z++) begin
        int t;
        if ($urandom_range(0, 29) == 0) t = int'($urandom_range(236, 255));
        else t = st + int'($urandom_range(0, 8)) - 5;
        if (t < 0) t = 0;
        if (t > 255) t = 255;
        a[z] = t * 16 + int'($urandom_range(0, 15));
      end
      set_adc(a[0], a[1]);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
